// File: rtl/sum_row_serializer.sv
// Row-to-beat serializer: captures a DIMENTION-element signed row in one cycle and emits it LANES elements per beat.
// Optional macro SUM_SER_SAT_EN saturates each emitted element from WIDTH_SUM to WIDTH_OUT signed bits.
module sum_row_serializer #(
  parameter int DIMENTION = 768,
  parameter int WIDTH_SUM = 32,
  parameter int LANES     = 16,
  parameter int WIDTH_OUT = 8,
  localparam int BEATS    = DIMENTION / LANES,
  localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1,
`ifdef SUM_SER_SAT_EN
  localparam int WO       = WIDTH_OUT
`else
  localparam int WO       = WIDTH_SUM
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DIMENTION*WIDTH_SUM-1:0] in_row,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*WO-1:0]            out_data,
  output logic                           out_last,
  output logic [CW-1:0]                  out_beat_idx,
  output logic                           busy
);

  localparam int BW = LANES * WIDTH_SUM;

  if (DIMENTION % LANES != 0) begin : g_chk_dim
    $error("DIMENTION must be a multiple of LANES");
  end
`ifdef SUM_SER_SAT_EN
  if (WIDTH_OUT < 2 || WIDTH_OUT >= WIDTH_SUM) begin : g_chk_wo
    $error("WIDTH_OUT must be in [2, WIDTH_SUM-1]");
  end
`else
  if (WIDTH_OUT < 1) begin : g_chk_wo
    $error("WIDTH_OUT must be positive");
  end
`endif

  // Handshake: a row moves on in_valid && in_ready, a beat moves on out_valid && out_ready;
  // valid never waits on ready, and in_ready depends on out_ready only during the last beat.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [DIMENTION*WIDTH_SUM-1:0] row_q, row_d;
  logic                           last_beat;
  logic                           xfer;
  logic                           accept;
  logic [BW-1:0]                  beat_raw;
  logic [LANES*WO-1:0]            beat_out;

  assign last_beat    = (cnt_q == CW'(BEATS - 1));
  assign out_valid    = (state_q == SEND);
  assign out_last     = out_valid && last_beat;
  assign out_beat_idx = cnt_q;
  assign busy         = out_valid;
  assign xfer         = out_valid && out_ready;
  assign in_ready     = !rst && ((state_q == IDLE) || (xfer && last_beat));
  assign accept       = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = accept ? SEND : IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      row_d = in_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Row storage carries no reset; out_data is forced to zero whenever no beat is valid.
  always_ff @(posedge clk) begin
    row_q <= row_d;
  end

  always_comb begin
    beat_raw = row_q[int'(cnt_q)*BW +: BW];
  end

`ifdef SUM_SER_SAT_EN
  localparam logic signed [WIDTH_SUM-1:0] SAT_MAX =
    {{(WIDTH_SUM-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [WIDTH_SUM-1:0] SAT_MIN =
    {{(WIDTH_SUM-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [WIDTH_SUM-1:0] elem;
    assign elem = beat_raw[j*WIDTH_SUM +: WIDTH_SUM];
    always_comb begin
      if (elem > SAT_MAX) begin
        beat_out[j*WO +: WO] = SAT_MAX[WO-1:0];
      end else if (elem < SAT_MIN) begin
        beat_out[j*WO +: WO] = SAT_MIN[WO-1:0];
      end else begin
        beat_out[j*WO +: WO] = elem[WO-1:0];
      end
    end
  end
`else
  assign beat_out = beat_raw;
`endif

  assign out_data = out_valid ? beat_out : '0;

endmodule

// File: tb/tb_sum_row_serializer.sv
// Self-checking bench for sum_row_serializer: negedge scoreboard plus directed row sequences and a saturation table.
module tb_sum_row_serializer;

  localparam int DIM   = 768;
  localparam int WS    = 32;
  localparam int LN    = 16;
  localparam int WOUT  = 8;
  localparam int BEATS = DIM / LN;
  localparam int CW    = $clog2(BEATS);
`ifdef SUM_SER_SAT_EN
  localparam int WO    = WOUT;
  localparam int SMAX  = (1 << (WOUT - 1)) - 1;
  localparam int SMIN  = -(1 << (WOUT - 1));
`else
  localparam int WO    = WS;
`endif
  localparam int DW    = LN * WO;
  localparam int EW    = DW + CW + 1;
  localparam int NV    = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DIM*WS-1:0] in_row;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [CW-1:0]     out_beat_idx;
  logic              busy;

  int                checks;
  int                errors;
  logic [EW-1:0]     exp_q[$];
  logic              mon_ready;

  typedef struct {
    logic [WS-1:0] in_val;
    logic [WO-1:0] exp_val;
  } vec_t;
  vec_t tab[NV];

  sum_row_serializer #(
    .DIMENTION(DIM),
    .WIDTH_SUM(WS),
    .LANES(LN),
    .WIDTH_OUT(WOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_row(in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .out_beat_idx(out_beat_idx),
    .busy(busy)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [DW+63:0] act, input logic [DW+63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WO-1:0] model_elem(input logic [WS-1:0] raw);
`ifdef SUM_SER_SAT_EN
    int v;
    v = $signed(raw);
    if (v > SMAX) return WO'(SMAX);
    if (v < SMIN) return WO'(SMIN);
    return WO'(v);
`else
    return raw;
`endif
  endfunction

  function automatic void push_row(input logic [DIM*WS-1:0] row);
    logic [DW-1:0] data;
    for (int k = 0; k < BEATS; k++) begin
      data = '0;
      for (int j = 0; j < LN; j++) begin
        data[j*WO +: WO] = model_elem(row[(k*LN+j)*WS +: WS]);
      end
      exp_q.push_back({data, CW'(k), (k == BEATS - 1)});
    end
  endfunction

  function automatic logic [DIM*WS-1:0] rand_row();
    logic [DIM*WS-1:0] r;
    for (int e = 0; e < DIM; e++) begin
      r[e*WS +: WS] = $urandom();
    end
    return r;
  endfunction

  // Scoreboard: rows are expanded into expected beats on acceptance and consumed as beats appear.
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready_during_rst", in_ready, 1'b0);
      exp_q.delete();
    end else begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("busy", busy, exp_q.size() != 0);
      mon_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      check("in_ready", in_ready, mon_ready);
      if (out_valid && exp_q.size() != 0) begin
        check("beat", {out_data, out_beat_idx, out_last}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && mon_ready) push_row(in_row);
    end
  end

  // Driver tasks: all start and end just after a rising edge.
  task automatic send_row(input logic [DIM*WS-1:0] row);
    logic ok;
    ok = 1'b0;
    in_row   = row;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_row   = rand_row();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!out_valid && exp_q.size() == 0) break;
    end
    check("idle_timeout", {out_valid, exp_q.size() != 0}, 2'b00);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DIM*WS-1:0] row;
    int n;
    int xf;
    int in_vals[NV] = '{300, -300, 127, -128, 5, 128, -129, -1};
    int sat_exp[NV] = '{127, -128, 127, -128, 5, 127, -128, -1};

    checks = 0;
    errors = 0;
    for (int i = 0; i < NV; i++) begin
      tab[i].in_val = WS'(in_vals[i]);
`ifdef SUM_SER_SAT_EN
      tab[i].exp_val = WO'(sat_exp[i]);
`else
      tab[i].exp_val = WO'(in_vals[i]);
`endif
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_beat_idx", out_beat_idx, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Ramp row with continuous ready
    out_ready = 1'b1;
    for (int e = 0; e < DIM; e++) row[e*WS +: WS] = WS'(e);
    send_row(row);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!out_valid) break;
      if (n == 0) check("first_beat_idx", out_beat_idx, '0);
      if (out_beat_idx == CW'(5)) check("beat5_lane3", out_data[3*WO +: WO], WO'(83));
      n++;
    end
    check("consecutive_beats", n, BEATS);
    check("valid_falls_after_last", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Stall every other cycle
    out_ready = 1'b0;
    send_row(rand_row());
    n  = 0;
    xf = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid) n++;
      if (out_valid && out_ready) xf++;
      if (out_valid && out_ready && out_last) break;
      @(posedge clk);
      #1;
      out_ready = !out_ready;
    end
    check("toggle_cycles", n, 96);
    check("toggle_transfers", xf, BEATS);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // Back-to-back rows; the pending row's data churns while the first row is emitted
    send_row(rand_row());
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_row = rand_row();
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
    check("accept_on_last", {out_valid, out_last, out_beat_idx}, {2'b11, CW'(BEATS - 1)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_row   = rand_row();
    @(negedge clk);
    check("no_bubble", {out_valid, out_beat_idx}, {1'b1, CW'(0)});
    wait_idle();

    // Reset in mid-row
    send_row(rand_row());
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_beat_idx == CW'(20)) break;
    end
    check("reached_beat20", out_beat_idx, CW'(20));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    send_row(rand_row());
    @(negedge clk);
    check("restart_idx", {out_valid, out_beat_idx}, {1'b1, CW'(0)});
    wait_idle();

    // Element table in the lanes of beat 0
    row = rand_row();
    for (int i = 0; i < NV; i++) row[i*WS +: WS] = tab[i].in_val;
    send_row(row);
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      check($sformatf("table_lane%0d", i), out_data[i*WO +: WO], tab[i].exp_val);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_row_serializer.md
SUM_ROW_SERIALIZER -- requirements
Module: sum_row_serializer

Interface
REQ-001 SHALL have parameter DIMENTION, default 768: elements per row vector.
REQ-002 SHALL have parameter WIDTH_SUM, default 32: signed element width of the loaded row.
REQ-003 SHALL have parameter LANES, default 16: elements emitted per output beat; DIMENTION SHALL be an integer multiple of LANES.
REQ-004 SHALL have parameter WIDTH_OUT, default 8: emitted element width, used only when SUM_SER_SAT_EN is defined (REQ-030).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port clk, input, 1: rising-edge clock for all state.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port in_valid, input, 1: a full row is presented on in_row.
REQ-009 Port in_ready, output, 1: the block accepts a row this cycle.
REQ-010 Port in_row, input, DIMENTION*WIDTH_SUM: signed row; element e occupies bits [(e+1)*WIDTH_SUM-1 : e*WIDTH_SUM].
REQ-011 Port out_valid, output, 1: out_data holds a valid beat.
REQ-012 Port out_ready, input, 1: the downstream consumer accepts the beat.
REQ-013 Port out_data, output, LANES*WO: beat payload, with WO = WIDTH_OUT if SUM_SER_SAT_EN is defined and WIDTH_SUM otherwise.
REQ-014 Port out_last, output, 1: the current beat is the final beat of the row.
REQ-015 Port out_beat_idx, output, clog2(DIMENTION/LANES) (minimum 1): index of the current beat.
REQ-016 Port busy, output, 1: a row is held and has not been fully emitted.

Function
REQ-017 SHALL define BEATS = DIMENTION/LANES; the default values give 48 beats.
REQ-018 SHALL implement the states IDLE and SEND.
REQ-019 In IDLE, in_ready SHALL be 1; in SEND, in_ready SHALL be 1 only when out_valid, out_ready and out_last are all 1 in the same cycle.
REQ-020 A row SHALL be accepted when in_valid and in_ready are both 1; the whole in_row SHALL be captured into an internal row register on that edge.
REQ-021 Acceptance SHALL move the block to SEND with beat counter 0; out_valid SHALL go to 1 on the following cycle, giving a latency of 1 cycle.
REQ-022 Beat k SHALL carry elements k*LANES+j for j = 0..LANES-1, with lane j at out_data bits [(j+1)*WO-1 : j*WO].
REQ-023 A beat SHALL be transferred when out_valid and out_ready are both 1; the counter SHALL then increment.
REQ-024 While out_valid is 1 and out_ready is 0, out_data, out_last and out_beat_idx SHALL stay stable.
REQ-025 out_last SHALL be 1 exactly when the counter equals BEATS-1.
REQ-026 On transfer of the last beat with no new row accepted, the block SHALL return to IDLE, and out_valid SHALL be 0 on the next cycle.
REQ-027 On transfer of the last beat with a row accepted in the same cycle, the block SHALL stay in SEND with counter 0 and the new row, with no bubble cycle.
REQ-028 busy SHALL equal 1 in SEND and 0 in IDLE.
REQ-029 in_row SHALL be ignored when no row is being accepted; an in_valid held high during SEND SHALL leave the held row unchanged.

Configuration
REQ-030 With macro SUM_SER_SAT_EN defined, each element SHALL be saturated from a signed WIDTH_SUM value to the signed WIDTH_OUT range [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
REQ-031 Without SUM_SER_SAT_EN, each element SHALL pass unchanged at WIDTH_SUM bits, and WIDTH_OUT SHALL be unused.

Reset
REQ-032 When rst is 1 on a clock edge, the block SHALL enter IDLE with counter 0.
REQ-033 Reset values SHALL be: out_valid 0, out_last 0, out_beat_idx 0, busy 0, out_data 0; in_ready SHALL be 0 while rst is asserted.
REQ-034 Reset in mid-row SHALL discard the held row; the first row after reset SHALL start at beat 0.

Verification
REQ-035 Row with element e = e, and out_ready held at 1 -> 48 consecutive beats; beat 5 lane 3 = 83; out_last only on beat 47; out_valid falls the cycle after beat 47.
REQ-036 out_ready toggled 1/0 every cycle -> all beats are stable while stalled; 96 cycles from the first out_valid to the last transfer; no beat dropped or repeated.
REQ-037 Second row held valid during the first row's beat 47 -> it is accepted in that cycle; beat 0 of row 2 follows immediately; in_ready = 0 during beats 0..46.
REQ-038 rst pulsed after beat 20 of a row -> out_valid = 0 and busy = 0 on the next cycle; the next row starts at out_beat_idx 0.
REQ-039 With SUM_SER_SAT_EN defined and WIDTH_OUT=8, elements 300, -300, 127, -128, 5 -> outputs 127, -128, 127, -128, 5.
REQ-040 in_valid=1 with new data in mid-SEND -> the held row is unchanged; emitted beats match the originally captured row.
